// File: rtl/eth_tx_arbiter_if.sv
// Signal bundle between the ARP/IP frame requesters, the Ethernet TX arbiter and the byte stream sink.
// master = arbiter side (drives grants, read strobes and the TX stream), slave = requester/sink side.
interface eth_tx_arbiter_if;
   logic        arp_req;
   logic [47:0] arp_dst_mac;
   logic [10:0] arp_len;
   logic [7:0]  arp_data;
   logic        arp_grant;
   logic        arp_rd;
   logic        ip_req;
   logic [47:0] ip_dst_mac;
   logic [10:0] ip_len;
   logic [7:0]  ip_data;
   logic        ip_grant;
   logic        ip_rd;
   logic [7:0]  txdata;
   logic        tx_en;
   logic        busy;

   modport master (
      input  arp_req, arp_dst_mac, arp_len, arp_data,
      input  ip_req, ip_dst_mac, ip_len, ip_data,
      output arp_grant, arp_rd, ip_grant, ip_rd,
      output txdata, tx_en, busy
   );

   modport slave (
      output arp_req, arp_dst_mac, arp_len, arp_data,
      output ip_req, ip_dst_mac, ip_len, ip_data,
      input  arp_grant, arp_rd, ip_grant, ip_rd,
      input  txdata, tx_en, busy
   );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin ARP/IP Ethernet TX arbiter: header insertion, show-ahead payload reads, inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad short payloads up to the 46-byte Ethernet minimum.
module eth_tx_arbiter #(
   parameter int IFG_CYCLES = 12,
   parameter int MAX_LEN    = 1500
) (
   input  logic             clock,
   input  logic             sclr,
   input  logic [47:0]      BOARD_MAC,
   eth_tx_arbiter_if.master bus
);
`ifdef ETH_TX_PAD_EN
   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, IFG} state_t;
`else
   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, IFG} state_t;
`endif

   localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
   localparam int          PAD_MIN   = 46;

   state_t      state_q;
   logic        sel_ip_q;
   logic        ptr_ip_q;
   logic [47:0] dst_q;
   logic [10:0] len_q;
   logic [10:0] cnt_q;
   logic [3:0]  idx_q;
   logic [15:0] ifg_q;
   logic [7:0]  txdata_q;
   logic        tx_en_q;
   logic        grant_q;
   logic        rd_q;

   logic        win_ip_d;
   logic [47:0] win_dst_d;
   logic [10:0] win_len_d;
   logic [7:0]  pay_data_d;
   logic        data_done_d;
   logic        pad_start_d;
   logic        frame_done_d;

   function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [47:0] dst,
                                           input logic [47:0] src, input logic is_ip);
      int sh;
      logic [7:0] b;
      if (idx < 4'd6) begin
         sh = 40 - 8 * int'(idx);
         b  = 8'(dst >> sh);
      end else if (idx < 4'd12) begin
         sh = 88 - 8 * int'(idx);
         b  = 8'(src >> sh);
      end else if (idx == 4'd12) begin
         b = 8'h08;
      end else begin
         b = is_ip ? 8'h00 : 8'h06;
      end
      return b;
   endfunction

   always_comb begin
      // With both requests pending the pointer names the preferred requester.
      win_ip_d   = bus.ip_req && (!bus.arp_req || ptr_ip_q);
      win_dst_d  = win_ip_d ? bus.ip_dst_mac : bus.arp_dst_mac;
      win_len_d  = win_ip_d ? bus.ip_len : bus.arp_len;
      if (win_len_d > MAX_LEN_C) win_len_d = MAX_LEN_C;
      pay_data_d = sel_ip_q ? bus.ip_data : bus.arp_data;
      data_done_d = !rd_q && ((state_q == HDR && idx_q == 4'd13) || state_q == PAYLOAD);
`ifdef ETH_TX_PAD_EN
      pad_start_d  = data_done_d && (len_q < 11'(PAD_MIN));
      frame_done_d = (data_done_d && !pad_start_d) || (state_q == PAD && cnt_q == 11'd1);
`else
      pad_start_d  = 1'b0;
      frame_done_d = data_done_d;
`endif
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         state_q  <= IDLE;
         txdata_q <= '0;
         tx_en_q  <= 1'b0;
         grant_q  <= 1'b0;
         rd_q     <= 1'b0;
         sel_ip_q <= 1'b0;
         ptr_ip_q <= 1'b0;
      end else if (frame_done_d) begin
         state_q  <= IFG;
         txdata_q <= '0;
         tx_en_q  <= 1'b0;
         grant_q  <= 1'b0;
         rd_q     <= 1'b0;
         ifg_q    <= 16'(IFG_CYCLES - 1);
      end else if (pad_start_d) begin
`ifdef ETH_TX_PAD_EN
         state_q  <= PAD;
`endif
         txdata_q <= '0;
         cnt_q    <= 11'(PAD_MIN) - len_q;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.arp_req || bus.ip_req) begin
                  state_q  <= HDR;
                  sel_ip_q <= win_ip_d;
                  ptr_ip_q <= !win_ip_d;
                  dst_q    <= win_dst_d;
                  len_q    <= win_len_d;
                  grant_q  <= 1'b1;
                  tx_en_q  <= 1'b1;
                  txdata_q <= win_dst_d[47:40];
                  idx_q    <= 4'd0;
               end
            end
            HDR: begin
               // Raise rd one cycle early so the first payload byte follows the ethertype directly.
               if (idx_q == 4'd12) begin
                  rd_q  <= (len_q != 11'd0);
                  cnt_q <= len_q;
               end
               if (idx_q != 4'd13) begin
                  idx_q    <= idx_q + 4'd1;
                  txdata_q <= hdr_byte(idx_q + 4'd1, dst_q, BOARD_MAC, sel_ip_q);
               end else begin
                  state_q  <= PAYLOAD;
                  txdata_q <= pay_data_d;
                  rd_q     <= (cnt_q > 11'd1);
                  cnt_q    <= cnt_q - 11'd1;
               end
            end
            PAYLOAD: begin
               txdata_q <= pay_data_d;
               rd_q     <= (cnt_q > 11'd1);
               cnt_q    <= cnt_q - 11'd1;
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
               cnt_q <= cnt_q - 11'd1;
            end
`endif
            IFG: begin
               if (ifg_q == 16'd0) state_q <= IDLE;
               else ifg_q <= ifg_q - 16'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.txdata    = txdata_q;
   assign bus.tx_en     = tx_en_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.arp_grant = grant_q && !sel_ip_q;
   assign bus.ip_grant  = grant_q && sel_ip_q;
   assign bus.arp_rd    = rd_q && !sel_ip_q;
   assign bus.ip_rd     = rd_q && sel_ip_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: frame contents, round-robin order, clamping, L=0, reset abort, request drop.
module tb_eth_tx_arbiter;
   logic        clock = 1'b0;
   logic        sclr;
   logic [47:0] board_mac;

   always #5 clock = ~clock;

   eth_tx_arbiter_if bus();

   eth_tx_arbiter #(.IFG_CYCLES(12), .MAX_LEN(1500)) dut (
      .clock     (clock),
      .sclr      (sclr),
      .BOARD_MAC (board_mac),
      .bus       (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int arp_k, ip_k;
   logic [7:0] q[$];
   logic [7:0] exp_q[$];
   int arp_rd_n, ip_rd_n, arp_g_n, ip_g_n, both_n;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dat(input logic is_ip, input int k);
      return is_ip ? 8'(k ^ 32'h5A) : 8'(k * 3 + 1);
   endfunction

   task automatic new_src();
      arp_k = 0;
      ip_k  = 0;
      bus.arp_data = dat(1'b0, 0);
      bus.ip_data  = dat(1'b1, 0);
   endtask

   // One clock; payload sources advance when their strobe was high at the edge.
   task automatic step();
      logic ar, ir;
      ar = bus.arp_rd;
      ir = bus.ip_rd;
      @(posedge clock);
      #1;
      if (ar) begin arp_k++; bus.arp_data = dat(1'b0, arp_k); end
      if (ir) begin ip_k++;  bus.ip_data  = dat(1'b1, ip_k);  end
   endtask

   task automatic build_exp(input logic [47:0] dst, input logic is_ip, input int len);
      exp_q = {};
      for (int i = 0; i < 6; i++) exp_q.push_back(8'(dst >> (40 - 8 * i)));
      for (int i = 0; i < 6; i++) exp_q.push_back(8'(board_mac >> (40 - 8 * i)));
      exp_q.push_back(8'h08);
      exp_q.push_back(is_ip ? 8'h00 : 8'h06);
      for (int k = 0; k < len; k++) exp_q.push_back(dat(is_ip, k));
`ifdef ETH_TX_PAD_EN
      for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
`endif
   endtask

   task automatic get_frame(input string tag, input int drop_idx);
      int w;
      int c;
      q = {};
      arp_rd_n = 0; ip_rd_n = 0; arp_g_n = 0; ip_g_n = 0; both_n = 0;
      w = 0;
      while (!bus.tx_en && w < 200) begin step(); w++; end
      if (!bus.tx_en) begin
         check({tag, "_start_timeout"}, 0, 1);
         return;
      end
      c = 0;
      while (bus.tx_en && c < 4000) begin
         q.push_back(bus.txdata);
         if (bus.arp_rd) arp_rd_n++;
         if (bus.ip_rd) ip_rd_n++;
         if (bus.arp_grant) arp_g_n++;
         if (bus.ip_grant) ip_g_n++;
         if ((bus.arp_grant && bus.ip_grant) || (bus.arp_rd && bus.ip_rd)) both_n++;
         if (q.size() == drop_idx) begin bus.arp_req = 1'b0; bus.ip_req = 1'b0; end
         step();
         c++;
      end
      check({tag, "_end_timeout"}, c < 4000, 1);
      check({tag, "_grant_excl"}, both_n, 0);
   endtask

   task automatic check_bytes(input string tag);
      int e0;
      check({tag, "_len"}, q.size(), exp_q.size());
      for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
         e0 = n_errors;
         check($sformatf("%s_byte%0d", tag, i), q[i], exp_q[i]);
         if (n_errors != e0) break;
      end
   endtask

   // Called at the first gap cycle with no request pending.
   task automatic check_ifg(input string tag);
      int z;
      check({tag, "_ifg_grant"}, {bus.arp_grant, bus.ip_grant}, 2'b00);
      z = 0;
      for (int i = 0; i < 12; i++) begin
         if (!bus.tx_en && bus.busy && !bus.arp_rd && !bus.ip_rd) z++;
         step();
      end
      check({tag, "_ifg_cycles"}, z, 12);
      check({tag, "_idle_after_ifg"}, bus.busy, 1'b0);
   endtask

   task automatic wait_idle(input string tag);
      int w;
      w = 0;
      while (bus.busy && w < 3000) begin step(); w++; end
      check({tag, "_idle_timeout"}, bus.busy, 1'b0);
   endtask

   initial begin
      sclr = 1'b1;
      board_mac = 48'h02_00_00_00_00_01;
      bus.arp_req = 1'b0; bus.arp_dst_mac = '0; bus.arp_len = '0;
      bus.ip_req  = 1'b0; bus.ip_dst_mac  = '0; bus.ip_len  = '0;
      new_src();
      step(); step(); step();
      check("rst_tx_en", bus.tx_en, 1'b0);
      check("rst_txdata", bus.txdata, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_grants", {bus.arp_grant, bus.ip_grant}, 2'b00);
      check("rst_rd", {bus.arp_rd, bus.ip_rd}, 2'b00);
      sclr = 1'b0;
      step();

      // ARP alone, broadcast, L=28
      new_src();
      bus.arp_dst_mac = 48'hFF_FF_FF_FF_FF_FF;
      bus.arp_len = 11'd28;
      bus.arp_req = 1'b1;
      step();
      bus.arp_req = 1'b0;
      check("arp_grant_n1", bus.arp_grant, 1'b1);
      get_frame("arp1", -1);
      build_exp(48'hFF_FF_FF_FF_FF_FF, 1'b0, 28);
      check_bytes("arp1");
`ifdef ETH_TX_PAD_EN
      check("arp1_txen_cycles", q.size(), 60);
`else
      check("arp1_txen_cycles", q.size(), 42);
`endif
      check("arp1_rd", arp_rd_n, 28);
      check("arp1_ip_grant", ip_g_n, 0);
      check_ifg("arp1");

      // Both requests from reset release: ARP, IP, ARP
      sclr = 1'b1;
      bus.arp_dst_mac = 48'hA1_A2_A3_A4_A5_A6; bus.arp_len = 11'd4;
      bus.ip_dst_mac  = 48'hB1_B2_B3_B4_B5_B6; bus.ip_len  = 11'd6;
      bus.arp_req = 1'b1; bus.ip_req = 1'b1;
      step();
      sclr = 1'b0;
      new_src();
      step();
      check("rr_start_after_release", bus.tx_en, 1'b1);
      get_frame("rr1", -1);
      check("rr1_ethertype", {q[12], q[13]}, 16'h0806);
      check("rr1_dst0", q[0], 8'hA1);
      check("rr1_owner", {arp_g_n > 0, ip_g_n > 0}, 2'b10);
      get_frame("rr2", -1);
      check("rr2_ethertype", {q[12], q[13]}, 16'h0800);
      check("rr2_dst0", q[0], 8'hB1);
      check("rr2_owner", {arp_g_n > 0, ip_g_n > 0}, 2'b01);
      check("rr2_rd", ip_rd_n, 6);
      get_frame("rr3", -1);
      check("rr3_ethertype", {q[12], q[13]}, 16'h0806);
      check("rr3_owner", {arp_g_n > 0, ip_g_n > 0}, 2'b10);
      bus.arp_req = 1'b0; bus.ip_req = 1'b0;
      wait_idle("rr");

      // IP with len 2000 clamps to 1500
      new_src();
      bus.ip_dst_mac = 48'h0A_0B_0C_0D_0E_0F;
      bus.ip_len = 11'd2000;
      bus.ip_req = 1'b1;
      step();
      bus.ip_req = 1'b0;
      get_frame("clamp", -1);
      build_exp(48'h0A_0B_0C_0D_0E_0F, 1'b1, 1500);
      check_bytes("clamp");
      check("clamp_rd", ip_rd_n, 1500);
      check("clamp_txen_cycles", q.size(), 1514);
      check_ifg("clamp");

      // IP with L=0
      new_src();
      bus.ip_dst_mac = 48'h12_34_56_78_9A_BC;
      bus.ip_len = 11'd0;
      bus.ip_req = 1'b1;
      step();
      bus.ip_req = 1'b0;
      get_frame("zero", -1);
      build_exp(48'h12_34_56_78_9A_BC, 1'b1, 0);
      check_bytes("zero");
      check("zero_rd", ip_rd_n, 0);
      check_ifg("zero");

      // Reset at payload byte 10 with the request still pending
      new_src();
      bus.arp_dst_mac = 48'h11_22_33_44_55_66;
      bus.arp_len = 11'd28;
      bus.arp_req = 1'b1;
      step();
      for (int i = 0; i < 24; i++) step();
      check("abort_at_pay10", {bus.tx_en, bus.txdata}, {1'b1, dat(1'b0, 10)});
      sclr = 1'b1;
      step();
      check("abort_tx_en", bus.tx_en, 1'b0);
      check("abort_grants", {bus.arp_grant, bus.ip_grant}, 2'b00);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_rd", {bus.arp_rd, bus.ip_rd}, 2'b00);
      sclr = 1'b0;
      new_src();
      step();
      check("restart_hdr0", {bus.tx_en, bus.txdata}, {1'b1, 8'h11});
      check("restart_grant", bus.arp_grant, 1'b1);
      bus.arp_req = 1'b0;
      wait_idle("restart");

      // ARP request dropped mid-payload
      new_src();
      bus.arp_dst_mac = 48'h02_AA_BB_CC_DD_EE;
      bus.arp_len = 11'd20;
      bus.arp_req = 1'b1;
      step();
      get_frame("drop", 16);
      build_exp(48'h02_AA_BB_CC_DD_EE, 1'b0, 20);
      check_bytes("drop");
      check("drop_rd", arp_rd_n, 20);
      check("drop_grant_held", arp_g_n, q.size());
      check_ifg("drop");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
